bus_sink_fifo: RTL

BUS_SINK_FIFO -- requirements
Module: bus_sink_fifo

---
 rtl/bus_sink_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/bus_sink_fifo.sv
// First-word-fall-through sink FIFO with a registered upstream ready and a
// sticky checker that flags a source changing or dropping data while stalled.
module bus_sink_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid_i,
    input  logic [DATA_W-1:0]        s_data_i,
    output logic                     s_ready_o,
    output logic                     m_valid_o,
    output logic [DATA_W-1:0]        m_data_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     proto_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              s_ready_q, s_ready_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              proto_err_q, proto_err_d;
    logic              push, pop, stall_now;

    always_comb begin
        push      = s_valid_i & s_ready_q;
        pop       = (count_q != '0) & m_ready_i;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        // Ready looks at the post-edge occupancy, so a full FIFO can never be pushed.
        s_ready_d = (count_d < CW'(DEPTH));
    end

    always_comb begin
        stall_now   = s_valid_i & ~s_ready_q;
        stall_d     = stall_now;
        hold_data_d = stall_now ? s_data_i : hold_data_q;
        proto_err_d = proto_err_q
                    | (stall_q & (~s_valid_i | (s_data_i != hold_data_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s_ready_q   <= 1'b0;
            stall_q     <= 1'b0;
            hold_data_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s_ready_q   <= s_ready_d;
            stall_q     <= stall_d;
            hold_data_q <= hold_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is not reset; it is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    always_comb begin
        m_valid_o   = (count_q != '0);
        m_data_o    = m_valid_o ? mem_q[rd_ptr_q] : '0;
        s_ready_o   = s_ready_q;
        count_o     = count_q;
        proto_err_o = proto_err_q;
    end

endmodule
